// File: rtl/inv_job_shell.sv
// Request/response shell in front of the Montgomery-domain Fp inverter: queues jobs,
// launches them one at a time, filters zero operands and aborts a hung inverter.
`ifndef WORD_SIZE
`define WORD_SIZE 256
`endif

module inv_job_shell #(
  parameter int WORD    = `WORD_SIZE,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 4,
  parameter int MAX_CYC = 2048
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WORD-1:0]  req_a,
  input  logic [TAG_W-1:0] req_tag,
  output logic             inv_start,
  output logic [WORD-1:0]  inv_a,
  output logic             inv_rst_n,
  input  logic [WORD-1:0]  inv_c,
  input  logic             inv_comp,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WORD-1:0]  rsp_c,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(MAX_CYC) + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   fcnt_t;
  typedef logic [CNT_W-1:0] wcnt_t;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ABORT  = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;

  // ---------------------------------------------------------------- request FIFO
  logic [WORD-1:0]  fifo_a_q   [DEPTH];
  logic [TAG_W-1:0] fifo_tag_q [DEPTH];
  ptr_t             wr_ptr_q, rd_ptr_q;
  fcnt_t            count_q;
  logic             push, pop, fifo_empty;
  logic [WORD-1:0]  head_a;
  logic [TAG_W-1:0] head_tag;

  logic [2:0]       state_q, state_d;
  logic             rsp_valid_q;

  assign req_ready  = (count_q != fcnt_t'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = req_valid && req_ready;
  // A job leaves the FIFO only when nothing is in flight or held at the response port.
  assign pop        = (state_q == S_IDLE) && !fifo_empty && !rsp_valid_q;
  assign head_a     = fifo_a_q[rd_ptr_q];
  assign head_tag   = fifo_tag_q[rd_ptr_q];

  // NOTE: storage array has no reset; contents are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_q[wr_ptr_q]   <= req_a;
      fifo_tag_q[wr_ptr_q] <= req_tag;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + fcnt_t'(1);
        2'b01:   count_q <= count_q - fcnt_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------- job FSM
  logic [WORD-1:0]  job_a_q, job_a_d;
  logic [TAG_W-1:0] job_tag_q, job_tag_d;
  wcnt_t            cnt_q, cnt_d;
  logic             abort_q;
  logic             rsp_load;
  logic [WORD-1:0]  rsp_c_n;
  logic [TAG_W-1:0] rsp_tag_n;
  logic             rsp_err_n;

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    job_a_d   = job_a_q;
    job_tag_d = job_tag_q;
    cnt_d     = cnt_q;
    rsp_load  = 1'b0;
    rsp_c_n   = '0;
    rsp_tag_n = job_tag_q;
    rsp_err_n = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          job_tag_d = head_tag;
          if (head_a == '0) begin
            // Zero has no inverse: answer immediately without touching the inverter.
            rsp_load  = 1'b1;
            rsp_tag_n = head_tag;
            rsp_err_n = 1'b1;
          end else begin
            job_a_d = head_a;
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (inv_comp) begin
          rsp_load = 1'b1;
          rsp_c_n  = inv_c;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + wcnt_t'(1);
          if (cnt_d == wcnt_t'(MAX_CYC - 1)) state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        rsp_load  = 1'b1;
        rsp_err_n = 1'b1;
        state_d   = S_SETTLE;
      end
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      job_a_q     <= '0;
      job_tag_q   <= '0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_c       <= '0;
      rsp_tag     <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state_q   <= state_d;
      job_a_q   <= job_a_d;
      job_tag_q <= job_tag_d;
      cnt_q     <= cnt_d;
      abort_q   <= (state_d == S_ABORT);
      if (rsp_load) begin
        rsp_valid_q <= 1'b1;
        rsp_c       <= rsp_c_n;
        rsp_tag     <= rsp_tag_n;
        rsp_err     <= rsp_err_n;
      end else if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign inv_start = (state_q == S_LAUNCH);
  assign inv_a     = job_a_q;
  assign inv_rst_n = rst_n & ~abort_q;
  assign busy      = !fifo_empty || (state_q != S_IDLE) || rsp_valid_q;

endmodule

// File: tb/tb_inv_job_shell.sv
// Directed + randomized bench for inv_job_shell with a behavioural Fp inverter model
// (p = 65521, R = 2^16) and a FIFO-order response scoreboard.
module tb_inv_job_shell;

  localparam int WORD    = 16;
  localparam int TAG_W   = 4;
  localparam int DEPTH   = 4;
  localparam int MAX_CYC = 64;
  localparam longint unsigned P     = 65521;
  localparam longint unsigned R_MOD = 65536 % 65521;
  localparam logic [WORD-1:0] HANG_A = 16'h0BAD;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [WORD-1:0]  req_a;
  logic [TAG_W-1:0] req_tag;
  logic             inv_start;
  logic [WORD-1:0]  inv_a;
  logic             inv_rst_n;
  logic [WORD-1:0]  inv_c;
  logic             inv_comp;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WORD-1:0]  rsp_c;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             busy;

  always #5 clk = ~clk;

  inv_job_shell #(.WORD(WORD), .TAG_W(TAG_W), .DEPTH(DEPTH), .MAX_CYC(MAX_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_tag(req_tag),
    .inv_start(inv_start), .inv_a(inv_a), .inv_rst_n(inv_rst_n),
    .inv_c(inv_c), .inv_comp(inv_comp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct packed {
    logic [WORD-1:0]  c;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  rsp_t exp_q[$];
  int   total = 0, bad = 0, cyc = 0;
  // inverter model and event monitors
  logic            m_busy = 1'b0;
  int              m_cd = 0;
  logic [WORD-1:0] m_res = '0;
  int              delay_cfg = 40;
  bit              rand_delay = 1'b0;
  int              start_cnt = 0, start_cyc = -1, comp_cyc = -1, rise_cyc = -1;
  logic [WORD-1:0] start_a = '0;
  int              abort_cnt = 0, abort_start = -1, abort_len = 0;
  logic            prev_abort = 1'b0, prev_rv = 1'b0, held = 1'b0;
  rsp_t            held_v;

  function automatic longint unsigned powmod(longint unsigned b, longint unsigned e);
    longint unsigned r = 1;
    b = b % P;
    while (e > 0) begin
      if (e[0]) r = (r * b) % P;
      b = (b * b) % P;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic logic [WORD-1:0] mont(longint unsigned x);
    return WORD'((x * R_MOD) % P);
  endfunction

  // Montgomery-form inverse: (aR)^-1 * R^2 = a^-1 R
  function automatic logic [WORD-1:0] inv_model(logic [WORD-1:0] a);
    longint unsigned r;
    r = powmod(longint'(a), P - 2);
    r = (r * R_MOD) % P;
    r = (r * R_MOD) % P;
    return WORD'(r);
  endfunction

  function automatic rsp_t expect_for(logic [WORD-1:0] a, logic [TAG_W-1:0] t);
    if (a == '0 || a == HANG_A) return '{c: '0, tag: t, err: 1'b1};
    return '{c: inv_model(a), tag: t, err: 1'b0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Evaluate this cycle's handshakes, advance one clock, then update the model/monitors.
  task automatic step();
    rsp_t e;
    if (!rst_n) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (req_valid && req_ready) exp_q.push_back(expect_for(req_a, req_tag));
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("unexpected_rsp", 64'(rsp_tag), 64'hFFFF);
        else begin
          e = exp_q.pop_front();
          check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
          check("rsp_c",   64'(rsp_c),   64'(e.c));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
        end
        held = 1'b0;
      end else if (rsp_valid) begin
        held   = 1'b1;
        held_v = '{c: rsp_c, tag: rsp_tag, err: rsp_err};
      end else held = 1'b0;
    end
    @(negedge clk);
    #1;
    cyc++;
    if (held) begin
      check("hold_valid", 64'(rsp_valid), 1);
      check("hold_data", 64'({rsp_c, rsp_tag, rsp_err}), 64'(held_v));
    end
    if (rsp_valid && !prev_rv) rise_cyc = cyc;
    prev_rv = rsp_valid;
    if (rst_n && !inv_rst_n) begin
      if (!prev_abort) begin
        abort_cnt++;
        abort_start = cyc;
        abort_len   = 0;
      end
      abort_len++;
      prev_abort = 1'b1;
    end else prev_abort = 1'b0;
    inv_comp = 1'b0;
    inv_c    = '0;
    if (!inv_rst_n) m_busy = 1'b0;
    else begin
      if (m_busy && m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin
          inv_comp = 1'b1;
          inv_c    = m_res;
          m_busy   = 1'b0;
          comp_cyc = cyc;
        end
      end
      if (inv_start) begin
        check("start_no_overlap", 64'(m_busy), 0);
        check("start_rsp_idle", 64'(rsp_valid), 0);
        start_cnt++;
        start_cyc = cyc;
        start_a   = inv_a;
        m_busy    = 1'b1;
        m_res     = inv_model(inv_a);
        m_cd      = (inv_a == HANG_A) ? -1 :
                    (rand_delay ? int'($urandom_range(1, 20)) : delay_cfg);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push(input logic [WORD-1:0] a, input logic [TAG_W-1:0] t);
    int n = 0;
    req_valid = 1'b1;
    req_a     = a;
    req_tag   = t;
    while (!req_ready && n < 500) begin
      step();
      n++;
    end
    check("push_ready", 64'(req_ready), 1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 500) begin
      step();
      n++;
    end
    check(tag, 64'(rsp_valid), 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check(tag, 64'({busy, exp_q.size() != 0}), 0);
  endtask

  initial begin
    int c0, s0, a0, st;
    logic [WORD-1:0] ra;
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_tag = '0;
    rsp_ready = 1'b1; inv_comp = 1'b0; inv_c = '0;
    #2;
    check("rst_req_ready", 64'(req_ready), 1);
    check("rst_outputs", 64'({rsp_valid, rsp_c, rsp_tag, rsp_err, inv_start, inv_a, busy}), 0);
    check("rst_inv_rst_n", 64'(inv_rst_n), 0);
    run(3);
    rst_n = 1'b1;
    run(2);
    check("rel_inv_rst_n", 64'(inv_rst_n), 1);

    // single job, comp 40 cycles after launch
    delay_cfg = 40;
    s0 = start_cnt;
    c0 = cyc;
    push(mont(3), 4'd5);
    step();
    check("t1_start_cyc", 64'(start_cyc), 64'(c0 + 2));
    check("t1_start_a", 64'(start_a), 64'(mont(3)));
    wait_rsp("t1_rsp_wait");
    check("t1_rsp_after_comp", 64'(rise_cyc), 64'(comp_cyc + 1));
    check("t1_rsp_c", 64'(rsp_c), 64'(inv_model(mont(3))));
    check("t1_rsp_tag", 64'(rsp_tag), 5);
    wait_idle("t1_idle", 200);
    check("t1_one_start", 64'(start_cnt), 64'(s0 + 1));

    // zero operand: response at edge 1, no launch
    s0 = start_cnt;
    c0 = cyc;
    push('0, 4'd9);
    step();
    check("t3_rsp_cyc", 64'(cyc - c0), 2);
    check("t3_rsp", 64'({rsp_valid, rsp_c, rsp_tag, rsp_err}), 64'({1'b1, 16'h0, 4'd9, 1'b1}));
    wait_idle("t3_idle", 50);
    check("t3_no_start", 64'(start_cnt), 64'(s0));

    // FIFO fill while a job is in flight, then ordered drain
    delay_cfg = 30;
    push(mont(7), 4'd0);
    run(2);
    for (int i = 1; i <= 4; i++) push(mont(20 + i), 4'(i));
    check("t2_full", 64'(req_ready), 0);
    check("t2_busy", 64'(busy), 1);
    wait_idle("t2_idle", 1000);

    // hung inverter: watchdog abort, then the next job runs normally
    delay_cfg = 10;
    s0 = start_cnt;
    a0 = abort_cnt;
    push(HANG_A, 4'd6);
    push(mont(9), 4'd7);
    st = start_cyc;
    check("t4_hang_start_a", 64'(start_a), 64'(HANG_A));
    run(MAX_CYC + 10);
    check("t4_abort_cnt", 64'(abort_cnt), 64'(a0 + 1));
    check("t4_abort_pos", 64'(abort_start), 64'(st + MAX_CYC));
    check("t4_abort_len", 64'(abort_len), 1);
    wait_idle("t4_idle", 200);
    check("t4_next_start", 64'(start_cnt), 64'(s0 + 2));
    check("t4_next_a", 64'(start_a), 64'(mont(9)));

    // response backpressure
    delay_cfg = 5;
    rsp_ready = 1'b0;
    push(mont(11), 4'd3);
    push(mont(12), 4'd4);
    wait_rsp("t5_rsp_wait");
    s0 = start_cnt;
    run(20);
    check("t5_no_start", 64'(start_cnt), 64'(s0));
    check("t5_held_tag", 64'(rsp_tag), 3);
    rsp_ready = 1'b1;
    wait_idle("t5_idle", 200);
    check("t5_second_start", 64'(start_cnt), 64'(s0 + 1));

    // randomized traffic with random inverter latency and backpressure
    rand_delay = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_valid = $urandom_range(0, 1) == 1;
      ra = ($urandom_range(0, 3) == 0) ? '0 : WORD'($urandom_range(1, int'(P) - 1));
      if (ra == HANG_A) ra = ra + 1'b1;
      req_a   = ra;
      req_tag = TAG_W'($urandom_range(0, 15));
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle("rand_idle", 3000);
    rand_delay = 1'b0;

    // reset during WAIT drops everything
    delay_cfg = 200;
    push(mont(5), 4'd1);
    push(mont(6), 4'd2);
    run(10);
    rst_n = 1'b0;
    #1;
    check("t6_rst_outputs", 64'({rsp_valid, rsp_c, rsp_tag, rsp_err, inv_start, inv_a, busy}), 0);
    check("t6_rst_ready", 64'({req_ready, inv_rst_n}), 64'(2'b10));
    s0 = start_cnt;
    run(2);
    rst_n = 1'b1;
    run(80);
    check("t6_no_rsp", 64'({rsp_valid, busy}), 0);
    check("t6_no_start", 64'(start_cnt), 64'(s0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_job_shell.md
Name: inv_job_shell

Overview:
- Request/response shell directly upstream of the Montgomery-domain Fp inverter. It queues inversion jobs, launches them one at a time on the inverter's start/a interface, and captures c on comp.
- Returns each result with its tag over a valid/ready response port.
- Filters zero operands, which have no inverse. A watchdog aborts a hung inverter.

Parameters:
- WORD, default `WORD_SIZE: operand/result width.
- TAG_W, default 4: job tag width.
- DEPTH, default 4: request FIFO depth; power of 2, minimum 2.
- MAX_CYC, default 2048: watchdog limit in cycles from inv_start to inv_comp.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  FIFO can accept a request
- req_a  in  WORD  operand, Montgomery form
- req_tag  in  TAG_W  job tag
- inv_start  out  1  one-cycle launch pulse to the inverter
- inv_a  out  WORD  operand to the inverter; stable from inv_start until inv_comp
- inv_rst_n  out  1  inverter reset; equals rst_n AND NOT abort_q
- inv_c  in  WORD  inverter result; valid while inv_comp=1
- inv_comp  in  1  inverter done pulse
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts the response
- rsp_c  out  WORD  result; 0 on error
- rsp_tag  out  TAG_W  tag of the completed job
- rsp_err  out  1  1 = zero operand or timeout
- busy  out  1  FIFO non-empty, or FSM not in IDLE, or rsp_valid=1

Behaviour:
- Reset: clk, reset rst_n, asynchronous, active-low. All outputs 0 except req_ready=1 and inv_rst_n=rst_n. FIFO empty, FSM in IDLE, cycle counter 0, abort_q=0.
- FIFO:
  - Push when req_valid && req_ready; req_ready = !full. No combinational pass-through.
  - Push into a full FIFO is impossible.
  - Push and pop in the same cycle are both allowed; count is unchanged.
  - Read and write pointers wrap modulo DEPTH.
- FSM states: IDLE, LAUNCH, WAIT, ABORT, SETTLE.
- IDLE:
  - Exits only if the FIFO is non-empty and rsp_valid=0.
  - Pop the head into the job register (a, tag).
  - Head a==0: write rsp_c=0, rsp_tag=tag, rsp_err=1, rsp_valid=1 in the same edge. The inverter is not launched. Stay in IDLE.
  - Head a!=0: go to LAUNCH.
- LAUNCH:
  - inv_start=1 for exactly this cycle; inv_a = job a.
  - Clear the counter; go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - inv_comp=1: register rsp_c=inv_c, rsp_tag, rsp_err=0, rsp_valid=1; go to IDLE.
  - Counter reaches MAX_CYC-1 without inv_comp: go to ABORT.
  - inv_comp and the timeout in the same cycle: inv_comp wins.
- ABORT:
  - abort_q=1 for one cycle, pulsing inv_rst_n low.
  - Register rsp_c=0, rsp_err=1, rsp_tag=job tag, rsp_valid=1; go to SETTLE.
- SETTLE: one cycle with abort_q=0 so the inverter leaves reset; then go to IDLE.
- Response hold:
  - rsp_* stay stable while rsp_valid && !rsp_ready.
  - rsp_valid clears on the accepting edge.
  - The next launch can happen no earlier than the cycle after acceptance. At most one job is in flight or held.
- inv_comp outside WAIT is ignored.
- inv_a holds the last job value while the inverter is idle.
- Minimum latency:
  - Push at edge 0, pop and job register load at edge 1, inv_start high in the cycle after edge 1.
  - rsp_valid rises on the edge where inv_comp is sampled.
  - Zero-operand response: rsp_valid at edge 1.
- Ordering: responses leave strictly in FIFO order.
- Reset mid-job: everything clears immediately. The inverter is reset too through inv_rst_n. Jobs in flight are dropped silently.

Test Plan:
- Single job, req_a=Mont(3), tag=5, inverter model with comp after 40 cycles -> exactly one inv_start pulse with inv_a=Mont(3); rsp_valid 1 cycle after comp; rsp_c=model result, rsp_tag=5, rsp_err=0.
- Four back-to-back pushes, tags 1..4, DEPTH=4, rsp_ready=1 -> req_ready=0 after the 4th push; responses in tag order 1,2,3,4; no overlapping inv_start pulses.
- req_a=0, tag=9 -> no inv_start; rsp_valid=1, rsp_c=0, rsp_err=1, rsp_tag=9 at edge 1.
- Inverter model never asserts comp, MAX_CYC=64 -> inv_rst_n low for exactly 1 cycle 64 cycles after inv_start; rsp_err=1; the next queued job then launches normally.
- rsp_ready held low for 20 cycles with jobs queued -> rsp_* stable; no new inv_start until 1 cycle after acceptance.
- rst_n asserted during WAIT -> all outputs at reset values in the same cycle; FIFO empty; no stale response after reset release.
